// File: rtl/crc16_append.sv
// Streaming CRC-16 (poly 0x8005, MSB first) generator: forwards sop/eop framed words
// through one output register and appends the final CRC as an extra eop word.
module crc16_append #(
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter logic [15:0] CRC_XOROUT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_sop,
    input  logic        i_eop,
    output logic        o_stall,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_eop,
    input  logic        i_stall,
    output logic        o_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BODY = 2'd1;
    localparam logic [1:0] CRC  = 2'd2;

    // One word of CRC-16 update, data bit 15 shifted in first.
    function automatic logic [15:0] crc16(input logic [15:0] data, input logic [15:0] crc);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        err_q, err_d;

    logic        outFree;
    logic        wordAccept;
    logic [15:0] crcSeed;
    logic [15:0] crcNext;

    assign outFree    = ~valid_q | ~i_stall;
    assign o_stall    = ~outFree | (state_q == CRC);
    assign wordAccept = i_valid & ~o_stall;

    // A sop word in IDLE restarts the CRC from CRC_INIT; otherwise the running value is used.
    assign crcSeed = (state_q == IDLE) ? CRC_INIT : crc_q;
    assign crcNext = crc16(i_data, crcSeed);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        data_d  = data_q;
        valid_d = valid_q & i_stall;
        sop_d   = sop_q;
        eop_d   = eop_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (wordAccept) begin
                    if (i_sop) begin
                        crc_d   = crcNext;
                        data_d  = i_data;
                        valid_d = 1'b1;
                        sop_d   = 1'b1;
                        eop_d   = 1'b0;
                        state_d = i_eop ? CRC : BODY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BODY: begin
                if (wordAccept) begin
                    crc_d   = crcNext;
                    data_d  = i_data;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b0;
                    err_d   = i_sop;
                    if (i_eop) begin
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                if (outFree) begin
                    data_d  = crc_q ^ CRC_XOROUT;
                    valid_d = 1'b1;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            data_q  <= 16'h0000;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_sop   = sop_q;
    assign o_eop   = eop_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_crc16_append.sv
// Bench for crc16_append: three parameterisations share one stimulus stream, an
// ordered scoreboard checks every transferred word, directed steps check timing.
module tb_crc16_append;

    localparam logic [15:0] INIT_P [3] = '{16'h0000, 16'h0000, 16'hFFFF};
    localparam logic [15:0] XOR_P  [3] = '{16'h0000, 16'hFFFF, 16'h0000};

    typedef struct packed {
        logic [2:0][15:0] d;
        logic             sop;
        logic             eop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] iData = 16'h0000;
    logic        iValid = 1'b0;
    logic        iSop = 1'b0;
    logic        iEop = 1'b0;
    logic        iStall = 1'b0;

    logic [15:0] oData [3];
    logic [2:0]  oValid, oSop, oEop, oErr, oStall;

    int          checkCount = 0;
    int          passCount = 0;

    exp_t        sbq[$];
    logic [15:0] mcrc [3];
    logic        inPkt = 1'b0;
    logic        expErr = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        crc16_append #(.CRC_INIT(INIT_P[g]), .CRC_XOROUT(XOR_P[g])) dut (
            .clk     (clk),
            .rst     (rst),
            .i_data  (iData),
            .i_valid (iValid),
            .i_sop   (iSop),
            .i_eop   (iEop),
            .o_stall (oStall[g]),
            .o_data  (oData[g]),
            .o_valid (oValid[g]),
            .o_sop   (oSop[g]),
            .o_eop   (oEop[g]),
            .i_stall (iStall),
            .o_err   (oErr[g])
        );
    end

    // Reference CRC step as polynomial division of (crc ^ data) * x^16 by 0x18005.
    function automatic logic [15:0] crcModel(input logic [15:0] crc, input logic [15:0] data);
        logic [31:0] r;
        r = {crc ^ data, 16'h0000};
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) r = r ^ (32'h0001_8005 << (i - 16));
        end
        return r[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s, input logic e);
        iValid = v;
        iData  = d;
        iSop   = s;
        iEop   = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard model: push expected words at the edge where the DUT accepts input.
    always @(posedge clk) begin
        exp_t        e;
        logic [15:0] nc [3];
        if (rst) begin
            sbq.delete();
            inPkt  <= 1'b0;
            expErr <= 1'b0;
        end else begin
            expErr <= 1'b0;
            if (iValid && !oStall[0]) begin
                if (!inPkt && !iSop) begin
                    expErr <= 1'b1;
                end else begin
                    if (inPkt && iSop) expErr <= 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        nc[k]   = crcModel(inPkt ? mcrc[k] : INIT_P[k], iData);
                        mcrc[k] <= nc[k];
                        e.d[k]  = iData;
                    end
                    e.sop = !inPkt;
                    e.eop = 1'b0;
                    sbq.push_back(e);
                    if (iEop) begin
                        for (int k = 0; k < 3; k++) e.d[k] = nc[k] ^ XOR_P[k];
                        e.sop = 1'b0;
                        e.eop = 1'b1;
                        sbq.push_back(e);
                        inPkt <= 1'b0;
                    end else begin
                        inPkt <= 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compare each transferred word and the error pulse away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) checkOutput("err", oErr[k], expErr);
        if (oValid[0] && !iStall) begin
            checkOutput("sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checkOutput("sb_data", oData[k], e.d[k]);
                    checkOutput("sb_valid", oValid[k], 1);
                    checkOutput("sb_sop", oSop[k], e.sop);
                    checkOutput("sb_eop", oEop[k], e.eop);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic accepted;
        int   len;

        // Reset state
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_valid", oValid[0], 0);
        checkOutput("rst_sop", oSop[0], 0);
        checkOutput("rst_eop", oEop[0], 0);
        checkOutput("rst_data", oData[0], 0);
        checkOutput("rst_err", oErr[0], 0);
        checkOutput("rst_stall", oStall[0], 0);

        // Single-word packet
        applyStimulus(1, 16'h0001, 1, 1);
        checkOutput("single_accept", oStall[0], 0);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("single_w0_data", oData[0], 16'h0001);
        checkOutput("single_w0_sop", oSop[0], 1);
        checkOutput("single_w0_eop", oEop[0], 0);
        checkOutput("single_stall_hi", oStall[0], 1);
        step();
        checkOutput("single_crc", oData[0], 16'h8005);
        checkOutput("single_crc_eop", oEop[0], 1);
        checkOutput("single_crc_sop", oSop[0], 0);
        checkOutput("single_stall_lo", oStall[0], 0);
        checkOutput("xorout_crc", oData[1], 16'h7FFA);
        step();
        checkOutput("single_drained", oValid[0], 0);

        // Two-word packet
        applyStimulus(1, 16'h0001, 1, 0);
        step();
        applyStimulus(1, 16'h0000, 0, 1);
        checkOutput("two_w0", oData[0], 16'h0001);
        checkOutput("two_stall_body", oStall[0], 0);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("two_w1", oData[0], 16'h0000);
        checkOutput("two_w1_valid", oValid[0], 1);
        step();
        checkOutput("two_crc", oData[0], 16'h8017);
        checkOutput("two_crc_eop", oEop[0], 1);
        step();

        // Backpressure on the CRC word
        applyStimulus(1, 16'h0001, 1, 1);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        step();
        iStall = 1'b1;
        applyStimulus(1, 16'h1234, 1, 1);
        #1;
        repeat (3) begin
            checkOutput("bp_hold_data", oData[0], 16'h8005);
            checkOutput("bp_hold_valid", oValid[0], 1);
            checkOutput("bp_stall", oStall[0], 1);
            step();
        end
        iStall = 1'b0;
        #1;
        checkOutput("bp_release_stall", oStall[0], 0);
        checkOutput("bp_release_data", oData[0], 16'h8005);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("bp_next_sop_data", oData[0], 16'h1234);
        checkOutput("bp_next_sop", oSop[0], 1);
        step();
        checkOutput("bp_next_crc_eop", oEop[0], 1);
        step();

        // Word without sop in IDLE
        applyStimulus(1, 16'h5555, 0, 0);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("nosop_err", oErr[0], 1);
        checkOutput("nosop_dropped", oValid[0], 0);
        step();
        checkOutput("nosop_err_pulse", oErr[0], 0);

        // sop mid-packet
        applyStimulus(1, 16'h0001, 1, 0);
        step();
        applyStimulus(1, 16'h0000, 1, 1);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("midsop_sop_forced", oSop[0], 0);
        checkOutput("midsop_data", oData[0], 16'h0000);
        checkOutput("midsop_err", oErr[0], 1);
        step();
        checkOutput("midsop_crc", oData[0], 16'h8017);
        checkOutput("midsop_err_pulse", oErr[0], 0);
        step();

        // Reset mid-packet
        applyStimulus(1, 16'hAAAA, 1, 0);
        step();
        applyStimulus(1, 16'hBBBB, 0, 0);
        step();
        applyStimulus(1, 16'hCCCC, 0, 0);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_valid", oValid[0], 0);
        checkOutput("midrst_data", oData[0], 0);
        checkOutput("midrst_sop", oSop[0], 0);
        checkOutput("midrst_eop", oEop[0], 0);
        checkOutput("midrst_stall", oStall[0], 0);
        applyStimulus(1, 16'h0000, 0, 0);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("midrst_nosop_err", oErr[0], 1);
        checkOutput("midrst_nosop_dropped", oValid[0], 0);
        step();
        applyStimulus(1, 16'h0001, 1, 1);
        step();
        applyStimulus(0, 16'h0000, 0, 0);
        checkOutput("midrst_w0", oData[0], 16'h0001);
        step();
        checkOutput("midrst_crc", oData[0], 16'h8005);
        step();

        // Random legal packets with random gaps and downstream stalls
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 6);
            for (int w = 0; w < len; w++) begin
                applyStimulus(1, 16'($urandom), w == 0, w == len - 1);
                accepted = 1'b0;
                for (int c = 0; c < 64 && !accepted; c++) begin
                    iStall = ($urandom_range(0, 3) == 0);
                    @(negedge clk);
                    accepted = !oStall[0];
                    step();
                end
                checkOutput("accept_timeout", accepted, 1);
            end
            applyStimulus(0, 16'h0000, 0, 0);
            repeat ($urandom_range(0, 2)) begin
                iStall = ($urandom_range(0, 3) == 0);
                step();
            end
        end

        iStall = 1'b0;
        repeat (6) step();
        checkOutput("drain_queue", sbq.size(), 0);
        checkOutput("drain_valid", oValid[0], 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
